// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: bus request/grant/response with byte lanes and load extension.
// Optional bus timeout abort enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_width,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  width_q;      // 0 byte, 1 half, 2 word
    logic        unsigned_q;
    logic [1:0]  off_q;

    logic        is_byte, is_half, misal_in;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [31:0] shifted, load_ext;

    // req_valid already encodes mem_read|mem_write; only mem_write selects direction
    logic        unused_in;
    assign unused_in = mem_read;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CLOG = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW   = (CLOG < 8) ? 8 : CLOG;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_fire;

    // Completion in the same cycle beats the abort
    assign tmo_fire = (tmo_cnt >= TMO_LAST) &&
                      (((state == S_REQ) && !bus_gnt) || ((state == S_WAIT) && !bus_rvalid));
`endif

    assign is_byte  = (mem_width == 3'b000);
    assign is_half  = (mem_width == 3'b001);
    assign misal_in = (is_half && addr[0]) || (!is_byte && !is_half && (addr[1:0] != 2'b00));

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = wdata;
        if (is_byte) begin
            be_in    = 4'b0001 << addr[1:0];
            wdata_in = {4{wdata[7:0]}};
        end else if (is_half) begin
            be_in    = 4'b0011 << {addr[1], 1'b0};
            wdata_in = {2{wdata[15:0]}};
        end
    end

    always_comb begin
        shifted  = bus_rdata >> {off_q, 3'b000};
        load_ext = shifted;
        case (width_q)
            2'd0:    load_ext = unsigned_q ? {24'b0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_ext = unsigned_q ? {16'b0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req_valid) state_nx = misal_in ? S_DONE : S_REQ;
            S_REQ: begin
                if (bus_gnt) state_nx = S_WAIT;
`ifdef LSU_TIMEOUT_EN
                else if (tmo_fire) state_nx = S_DONE;
`endif
            end
            S_WAIT: begin
                if (bus_rvalid) state_nx = S_DONE;
`ifdef LSU_TIMEOUT_EN
                else if (tmo_fire) state_nx = S_DONE;
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign done    = (state == S_DONE);
    assign bus_req = (state == S_REQ);
    assign stall   = req_valid && (state != S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            width_q    <= '0;
            unsigned_q <= 1'b0;
            off_q      <= '0;
            rdata      <= '0;
            misaligned <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt     <= '0;
            bus_timeout <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (misal_in) begin
                            misaligned <= 1'b1;
                            rdata      <= '0;
                        end else begin
                            bus_addr   <= {addr[31:2], 2'b00};
                            bus_we     <= mem_write;
                            bus_be     <= be_in;
                            bus_wdata  <= wdata_in;
                            width_q    <= is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
                            unsigned_q <= mem_unsigned;
                            off_q      <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt    <= '0;
`endif
                        end
                    end
                end
                S_WAIT: begin
                    if (bus_rvalid) rdata <= bus_we ? '0 : load_ext;
                end
                S_DONE: begin
                    misaligned <= 1'b0;
                    rdata      <= '0;
                end
                default: ;
            endcase
`ifdef LSU_TIMEOUT_EN
            if ((state == S_REQ) || (state == S_WAIT)) tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_fire) begin
                bus_timeout <= 1'b1;
                rdata       <= '0;
            end
            if (state == S_DONE) bus_timeout <= 1'b0;
`endif
        end
    end

`ifndef LSU_TIMEOUT_EN
    assign bus_timeout = 1'b0;
`endif

endmodule
